// File: rtl/count_checker_pkg.sv
// Shared types and helpers for the count_checker sequence monitor.
// Holds the FSM state encoding, default sizing and the modulo increment.
package count_checker_pkg;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        SYNC = 2'd1,
        LOCK = 2'd2
    } state_e;

    localparam int DEF_WIDTH  = 4;
    localparam int DEF_ERR_W  = 8;
    localparam int DEF_LOCK_N = 2;

    // Increment with natural wrap at 2^width; width must stay below 32.
    function automatic logic [31:0] mod_inc(input logic [31:0] value, input int width);
        logic [31:0] mask;
        mask = (32'd1 << width) - 32'd1;
        return (value + 32'd1) & mask;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of rolling over.
// Used as the sequence-error tally of count_checker.
module sat_counter #(
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             clear_i,
    output logic [ERR_W-1:0] count_o
);

    logic [ERR_W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (inc_i && (count_q != '1)) begin
            count_q <= count_q + ERR_W'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/count_checker.sv
// Checks that a sampled count stream advances by +1 mod 2^WIDTH; locks, flags errors, pulses on wrap.
// Define COUNT_CHECKER_RESTART_EN to treat a locked jump to zero as an upstream restart, not an error.
module count_checker
    import count_checker_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int ERR_W  = DEF_ERR_W,
    parameter int LOCK_N = DEF_LOCK_N
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [WIDTH-1:0] CNT_IN,
    output logic             LOCKED,
    output logic             ERR,
    output logic             WRAP,
    output logic [ERR_W-1:0] ERR_CNT,
    output logic [WIDTH-1:0] EXP_OUT
);

    localparam logic [WIDTH-1:0] MAX_VAL  = '1;
    localparam logic [3:0]       LOCK_N_C = 4'(LOCK_N);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic [3:0]       good_q, good_d;
    logic             locked_q, locked_d;
    logic             err_q, err_d;
    logic             wrap_q, wrap_d;

    logic [WIDTH-1:0] prev_inc;
    logic             match;
    logic             restart;

    assign prev_inc = WIDTH'(mod_inc(32'(prev_q), WIDTH));
    assign match    = (CNT_IN == prev_inc);

`ifdef COUNT_CHECKER_RESTART_EN
    // A locked drop to zero means the upstream counter was reset, not that it misbehaved.
    assign restart = (CNT_IN == '0) && (prev_inc != '0);
`else
    assign restart = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= HUNT;
            prev_q   <= '0;
            exp_q    <= '0;
            good_q   <= '0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            exp_q    <= exp_d;
            good_q   <= good_d;
            locked_q <= locked_d;
            err_q    <= err_d;
            wrap_q   <= wrap_d;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        good_d  = good_q;
        if (EN) begin
            prev_d = CNT_IN;
            case (state_q)
                HUNT: begin
                    good_d  = '0;
                    state_d = SYNC;
                end
                SYNC: begin
                    if (match) begin
                        good_d = good_q + 4'd1;
                        if ((good_q + 4'd1) == LOCK_N_C) begin
                            state_d = LOCK;
                        end
                    end else begin
                        good_d = '0;
                    end
                end
                LOCK: begin
                    if (!match) begin
                        good_d  = '0;
                        state_d = SYNC;
                    end
                end
                default: begin
                    good_d  = '0;
                    state_d = HUNT;
                end
            endcase
        end
    end

    always_comb begin
        err_d    = 1'b0;
        wrap_d   = 1'b0;
        exp_d    = exp_q;
        locked_d = (state_d == LOCK);
        if (EN) begin
            exp_d = WIDTH'(mod_inc(32'(CNT_IN), WIDTH));
            if (state_q == LOCK) begin
                if (match) begin
                    wrap_d = (prev_q == MAX_VAL);
                end else begin
                    err_d = !restart;
                end
            end
        end
    end

    sat_counter #(
        .ERR_W (ERR_W)
    ) u_err_cnt (
        .clk     (CLK),
        .rst_n   (RST),
        .inc_i   (err_d),
        .clear_i (1'b0),
        .count_o (ERR_CNT)
    );

    assign LOCKED  = locked_q;
    assign ERR     = err_q;
    assign WRAP    = wrap_q;
    assign EXP_OUT = exp_q;

endmodule

// File: tb/tb_count_checker.sv
// Self-checking bench for count_checker: directed scenarios plus a random stream
// compared against a behavioural run-length model; a second instance uses a 2-bit error tally.
module tb_count_checker;

`ifdef COUNT_CHECKER_RESTART_EN
    localparam bit RESTART = 1'b1;
`else
    localparam bit RESTART = 1'b0;
`endif
    localparam int LOCK_N = 2;

    logic       CLK;
    logic       RST;
    logic       EN;
    logic [3:0] CNT_IN;

    logic       locked, err, wrap;
    logic [7:0] err_cnt;
    logic [3:0] exp_out;
    logic       s_locked, s_err, s_wrap;
    logic [1:0] s_err_cnt;
    logic [3:0] s_exp_out;

    count_checker #(.WIDTH(4), .ERR_W(8), .LOCK_N(LOCK_N)) u_dut (
        .CLK(CLK), .RST(RST), .EN(EN), .CNT_IN(CNT_IN),
        .LOCKED(locked), .ERR(err), .WRAP(wrap), .ERR_CNT(err_cnt), .EXP_OUT(exp_out)
    );

    count_checker #(.WIDTH(4), .ERR_W(2), .LOCK_N(LOCK_N)) u_dut_sat (
        .CLK(CLK), .RST(RST), .EN(EN), .CNT_IN(CNT_IN),
        .LOCKED(s_locked), .ERR(s_err), .WRAP(s_wrap), .ERR_CNT(s_err_cnt), .EXP_OUT(s_exp_out)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_vec  = 0;
    int n_fail = 0;

    // Behavioural model: last sample, run length of correct increments, lock flag, tallies.
    bit m_have, m_locked, m_err, m_wrap;
    int m_prev, m_run, m_cnt8, m_cnt2, m_exp;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
        end
    endtask

    function automatic void model_reset();
        m_have = 0; m_locked = 0; m_err = 0; m_wrap = 0;
        m_prev = 0; m_run = 0; m_cnt8 = 0; m_cnt2 = 0; m_exp = 0;
    endfunction

    function automatic void model_step(input bit en, input int cnt);
        int want;
        m_err  = 0;
        m_wrap = 0;
        if (!en) return;
        if (m_have) begin
            want = (m_prev + 1) % 16;
            if (m_locked) begin
                if (cnt == want) begin
                    m_wrap = (cnt == 0);
                end else begin
                    if (!(RESTART && cnt == 0)) begin
                        m_err = 1;
                        if (m_cnt8 < 255) m_cnt8++;
                        if (m_cnt2 < 3) m_cnt2++;
                    end
                    m_locked = 0;
                    m_run    = 0;
                end
            end else if (cnt == want) begin
                m_run++;
                if (m_run >= LOCK_N) m_locked = 1;
            end else begin
                m_run = 0;
            end
        end
        m_have = 1;
        m_prev = cnt;
        m_exp  = (cnt + 1) % 16;
    endfunction

    task automatic check_all();
        check("locked",    32'(locked),    32'(m_locked));
        check("err",       32'(err),       32'(m_err));
        check("wrap",      32'(wrap),      32'(m_wrap));
        check("err_cnt",   32'(err_cnt),   32'(m_cnt8));
        check("exp_out",   32'(exp_out),   32'(m_exp));
        check("s_locked",  32'(s_locked),  32'(m_locked));
        check("s_err",     32'(s_err),     32'(m_err));
        check("s_wrap",    32'(s_wrap),    32'(m_wrap));
        check("s_err_cnt", 32'(s_err_cnt), 32'(m_cnt2));
        check("s_exp_out", 32'(s_exp_out), 32'(m_exp));
    endtask

    task automatic step(input bit en, input int cnt);
        EN     = en;
        CNT_IN = 4'(cnt);
        @(posedge CLK);
        model_step(en, cnt);
        #1;
        check_all();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_locked"},  32'(locked),    32'd0);
        check({tag, "_err"},     32'(err),       32'd0);
        check({tag, "_wrap"},    32'(wrap),      32'd0);
        check({tag, "_err_cnt"}, 32'(err_cnt),   32'd0);
        check({tag, "_exp"},     32'(exp_out),   32'd0);
        check({tag, "_s_cnt"},   32'(s_err_cnt), 32'd0);
    endtask

    initial begin
        int p;
        int v;
        int last;
        bit en;
        RST    = 1'b0;
        EN     = 1'b0;
        CNT_IN = '0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        check_zero("reset");
        RST = 1'b1;

        // Basic lock on 0,1,2.
        for (int i = 0; i <= 2; i++) step(1, i);
        check("lock_locked", 32'(locked), 32'd1);
        check("lock_exp", 32'(exp_out), 32'd3);

        // Wrap through 13,14,15,0,1.
        for (int i = 3; i <= 15; i++) step(1, i);
        step(1, 0);
        check("wrap_pulse", 32'(wrap), 32'd1);
        step(1, 1);
        check("wrap_once", 32'(wrap), 32'd0);
        check("wrap_locked", 32'(locked), 32'd1);

        // Sequence error 4,5,7 then relock on 8,9.
        for (int i = 2; i <= 5; i++) step(1, i);
        step(1, 7);
        check("err_pulse", 32'(err), 32'd1);
        check("err_cnt1", 32'(err_cnt), 32'd1);
        check("err_unlock", 32'(locked), 32'd0);
        step(1, 8);
        step(1, 9);
        check("relock", 32'(locked), 32'd1);

        // Enable gating: locked at 6, five idle cycles with noise, then 7.
        for (int i = 10; i <= 22; i++) step(1, i % 16);
        for (int i = 0; i < 5; i++) step(0, int'($urandom_range(15)));
        step(1, 7);
        check("gate_err", 32'(err), 32'd0);
        check("gate_locked", 32'(locked), 32'd1);

        // Upstream restart: locked at 9, then 0,0,1,2.
        step(1, 8);
        step(1, 9);
        step(1, 0);
        check("restart_err", 32'(err), 32'(!RESTART));
        step(1, 0);
        step(1, 1);
        step(1, 2);
        check("restart_locked", 32'(locked), 32'd1);
        check("restart_cnt", 32'(err_cnt), 32'(RESTART ? 1 : 2));

        // Five locked mismatches with relock between each; none lands on zero.
        p = 2;
        for (int r = 0; r < 5; r++) begin
            v = (p + 5) % 16;
            step(1, v);
            step(1, (v + 1) % 16);
            step(1, (v + 2) % 16);
            p = (v + 2) % 16;
        end
        check("sat_hold", 32'(s_err_cnt), 32'd3);
        check("wide_cnt", 32'(err_cnt), 32'(RESTART ? 6 : 7));

        // Asynchronous reset while locked.
        #2;
        RST = 1'b0;
        #1;
        model_reset();
        check_zero("async_rst");
        @(posedge CLK);
        #2;
        RST = 1'b1;

        // Random stream: mostly counting, with glitches, zeros and idle cycles.
        last = 0;
        for (int i = 0; i < 3000; i++) begin
            en = ($urandom_range(4) != 0);
            case ($urandom_range(15))
                0:       v = 0;
                1, 2:    v = int'($urandom_range(15));
                3:       v = last;
                default: v = (last + 1) % 16;
            endcase
            step(en, v);
            if (en) last = v;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
